// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The state encoding, count sizing and divide-by-zero quotient pattern live here.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Sliced down to the operand width by the user.
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand and result handshake bundle for seq_divider.
// The producer/consumer side uses master; the divider uses slave.
interface seq_divider_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_fullsubtractor.sv
// Single-bit full subtractor cell, the borrow-chain counterpart of the full adder.
module fullsubtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock through a ripple
// subtractor chain, result held until the consumer takes it.
module seq_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int CNT_W = count_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remd_q, remd_d;
    logic               dbz_q, dbz_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     divisor_ext_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH+1:0]   borrow_s;
    logic               borrow_out_s;
    logic               last_iter_s;
    logic               unused_s;

    assign shifted_s     = {rem_q, q_q[WIDTH-1]};
    assign divisor_ext_s = {1'b0, div_q};
    assign borrow_s[0]   = 1'b0;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        fullsubtractor u_fs (
            .a    (shifted_s[i]),
            .b    (divisor_ext_s[i]),
            .bin  (borrow_s[i]),
            .d    (trial_s[i]),
            .bout (borrow_s[i+1])
        );
    end

    assign borrow_out_s = borrow_s[WIDTH+1];
    assign last_iter_s  = (cnt_q == CNT_W'(WIDTH - 1));
    // A non-borrowing trial is always below the divisor, so its top bit is zero.
    assign unused_s     = trial_s[WIDTH];

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            q_q         <= {WIDTH{1'b0}};
            div_q       <= {WIDTH{1'b0}};
            quot_q      <= {WIDTH{1'b0}};
            remd_q      <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            div_q       <= div_d;
            quot_q      <= quot_d;
            remd_q      <= remd_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == {WIDTH{1'b0}}) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_iter_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Iteration datapath and registered handshake/result outputs.
    always_comb begin
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        q_d         = q_q;
        div_d       = div_q;
        quot_d      = quot_q;
        remd_d      = remd_q;
        dbz_d       = dbz_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    div_d = bus.divisor;
                    cnt_d = {CNT_W{1'b0}};
                    rem_d = {WIDTH{1'b0}};
                    q_d   = bus.dividend;
                    if (bus.divisor == {WIDTH{1'b0}}) begin
                        quot_d = DIV0_QUOTIENT[WIDTH-1:0];
                        remd_d = bus.dividend;
                        dbz_d  = 1'b1;
                    end else begin
                        dbz_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!borrow_out_s) begin
                    rem_d = trial_s[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted_s[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end
                if (last_iter_s) begin
                    quot_d = q_d;
                    remd_d = rem_d;
                    dbz_d  = 1'b0;
                end else begin
                    quot_d = quot_q;
                end
            end
            DONE:    cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remd_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against a plain arithmetic model.
module tb_seq_divider;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << W) - 1;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    task automatic check_reset_state(input string tag);
        check_val({tag, ".in_ready"},  int'(bus.in_ready),    1);
        check_val({tag, ".out_valid"}, int'(bus.out_valid),   0);
        check_val({tag, ".quotient"},  int'(bus.quotient),    0);
        check_val({tag, ".remainder"}, int'(bus.remainder),   0);
        check_val({tag, ".dbz"},       int'(bus.div_by_zero), 0);
    endtask

    task automatic run_op(input int a, input int b, input int stall, input string tag);
        int eq, er, ez, lat, wait_n;
        ref_div(a, b, eq, er, ez);
        @(negedge clk);
        wait_n = 0;
        while (!bus.in_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (!bus.in_ready) begin
            check_val({tag, ".ready_timeout"}, int'(bus.in_ready), 1);
            return;
        end
        bus.in_valid  = 1'b1;
        bus.dividend  = W'(a);
        bus.divisor   = W'(b);
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        // Garbage on the operand side while busy must be ignored.
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 100);
        bus.in_valid = 1'b0;
        check_val({tag, ".latency"},   lat, (ez != 0) ? 1 : W + 1);
        check_val({tag, ".quotient"},  int'(bus.quotient),    eq);
        check_val({tag, ".remainder"}, int'(bus.remainder),   er);
        check_val({tag, ".dbz"},       int'(bus.div_by_zero), ez);
        check_val({tag, ".busy_ready"}, int'(bus.in_ready),   0);
        if (ez == 0) begin
            check_val({tag, ".identity"},
                      int'(bus.quotient) * b + int'(bus.remainder), a);
            check_val({tag, ".rem_lt_div"}, int'(int'(bus.remainder) < b), 1);
        end
        repeat (stall) begin
            @(negedge clk);
            check_val({tag, ".hold_valid"}, int'(bus.out_valid), 1);
            check_val({tag, ".hold_quot"},  int'(bus.quotient),  eq);
            check_val({tag, ".hold_rem"},   int'(bus.remainder), er);
            check_val({tag, ".hold_ready"}, int'(bus.in_ready),  0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val({tag, ".valid_drop"}, int'(bus.out_valid), 0);
        check_val({tag, ".ready_back"}, int'(bus.in_ready),  1);
    endtask

    initial begin
        int seen, a, b, sel;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        run_op(100, 7,  0,  "d100_7");
        run_op(255, 1,  0,  "d255_1");
        run_op(5,   9,  0,  "d5_9");
        run_op(37,  0,  0,  "d37_0");
        run_op(200, 13, 20, "bp200_13");

        // Reset four cycles into a 99/4 run.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = W'(99);
        bus.divisor  = W'(4);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrun_rst");
        rst  = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check_val("midrun_no_valid", seen, 0);
        run_op(99, 4, 0, "d99_4");

        for (int i = 0; i < 2000; i++) begin
            a   = int'($urandom_range(0, 255));
            sel = int'($urandom_range(0, 15));
            case (sel)
                0:       b = 0;
                1:       b = 1;
                2:       b = 255;
                default: b = int'($urandom_range(0, 255));
            endcase
            run_op(a, b, int'($urandom_range(0, 3)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
